// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the multi-cycle ALU (ula_multiciclo):
//   - 4-bit opcode map of the `controle` input (OP_ADD .. OP_SNE)
//   - control FSM state type ula_state_t (IDLE, RUN, FIX)
// ---------------------------------------------------------------------------
package ula_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_SGT = 4'b0111;
  localparam logic [3:0] OP_SEQ = 4'b1000;
  localparam logic [3:0] OP_SLE = 4'b1001;
  localparam logic [3:0] OP_SGE = 4'b1010;
  localparam logic [3:0] OP_SLL = 4'b1011;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_SNE = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } ula_state_t;

endpackage

// File: rtl/ula_muldiv_iter.sv
// ---------------------------------------------------------------------------
// ula_muldiv_iter
// Iterative unsigned multiply / divide core working on operand magnitudes.
// A 2*WIDTH shift register {hi, lo} is stepped once per clock by a shared
// (WIDTH+1)-bit adder: shift-add for MUL, restoring subtract for DIV.
// Optional feature macro: ULA_DIV_EN (builds the divide step and div_i port).
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   load_i       : start a new operation (loads operands, counter = WIDTH)
//   div_i        : 1 = divide, 0 = multiply (only with ULA_DIV_EN)
//   op_a_i       : multiplier / dividend magnitude
//   op_b_i       : multiplicand / divisor magnitude
//   last_o       : the step performed in this cycle is the final one
//   hi_o, lo_o   : product high/low, or remainder/quotient when finished
// ---------------------------------------------------------------------------
module ula_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
`ifdef ULA_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   acc_in, addend, sum;
`ifdef ULA_DIV_EN
  logic             div_q;
`endif

  always_comb begin
    // Multiply: add multiplicand to the high half when the current
    // multiplier bit (lo[0]) is set, then shift the whole pair right.
    acc_in = {1'b0, hi_q};
    addend = lo_q[0] ? {1'b0, b_q} : '0;
`ifdef ULA_DIV_EN
    // Divide: shift the next dividend bit into the partial remainder and
    // add the negated divisor on the same adder.
    if (div_q) begin
      acc_in = {hi_q, lo_q[WIDTH-1]};
      addend = ~{1'b0, b_q} + (WIDTH+1)'(1);
    end
`endif
    sum = acc_in + addend;

    hi_d = sum[WIDTH:1];
    lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ULA_DIV_EN
    if (div_q) begin
      // The partial remainder is always below the divisor, so the
      // difference fits in WIDTH+1 bits and its top bit is the borrow.
      if (sum[WIDTH]) begin
        hi_d = acc_in[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_d = sum[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
`endif
    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
`ifdef ULA_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (load_i) begin
      cnt_q <= CNT_W'(WIDTH);
      hi_q  <= '0;
      lo_q  <= op_a_i;
      b_q   <= op_b_i;
`ifdef ULA_DIV_EN
      div_q <= div_i;
`endif
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
// Multi-cycle ALU with start/busy/done handshake. Single-cycle ops complete
// on the accepting edge; MUL (and DIV when built) run WIDTH iterations in
// ula_muldiv_iter, then a FIX cycle applies sign correction.
// Optional feature macro: ULA_DIV_EN (divider; otherwise 0011 is unknown).
// Ports:
//   clock, reset      : clock, asynchronous active-high reset
//   start, controle   : launch request and 4-bit opcode
//   signed_op         : two's-complement compare / mul / div / right shift
//   in1, in2          : operands
//   out_res           : primary result (LO for mul/div)
//   out_hi, out_lo    : product high/low or remainder/quotient
//   out1              : compare flag
//   div_zero          : last division had a zero divisor
//   busy, done        : operation in flight / one-cycle completion pulse
// ---------------------------------------------------------------------------
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       controle,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out_res,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             out1,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int SHAMT_W = $clog2(WIDTH);

  ula_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic             flag_q, flag_d, dz_q, dz_d, done_q, done_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_flag, lt, gt, eq;
  logic [SHAMT_W-1:0] shamt;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               iter_load, iter_last;
  logic [WIDTH-1:0]   iter_hi, iter_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
`ifdef ULA_DIV_EN
  logic               div_op_q, rem_neg_q;
`endif

  // Single-cycle datapath
  assign shamt = in2[SHAMT_W-1:0];
  assign eq    = (in1 == in2);
  assign lt    = signed_op ? ($signed(in1) < $signed(in2)) : (in1 < in2);
  assign gt    = signed_op ? ($signed(in1) > $signed(in2)) : (in1 > in2);

  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    case (controle)
      OP_ADD: alu_res = in1 + in2;
      OP_SUB: alu_res = in1 - in2;
      OP_AND: alu_res = in1 & in2;
      OP_OR:  alu_res = in1 | in2;
      OP_SLT: alu_flag = lt;
      OP_SGT: alu_flag = gt;
      OP_SEQ: alu_flag = eq;
      OP_SLE: alu_flag = lt | eq;
      OP_SGE: alu_flag = gt | eq;
      OP_SNE: alu_flag = ~eq;
      OP_SLL: alu_res = in1 << shamt;
      OP_SRL: alu_res = signed_op ? WIDTH'($signed(in1) >>> shamt) : (in1 >> shamt);
      default: alu_res = '0;
    endcase
    if (alu_flag) alu_res = WIDTH'(1);
  end

  // The iterative core works on magnitudes; signs are reapplied in FIX.
  assign a_neg = signed_op & in1[WIDTH-1];
  assign b_neg = signed_op & in2[WIDTH-1];
  assign mag_a = a_neg ? -in1 : in1;
  assign mag_b = b_neg ? -in2 : in2;
  assign neg_d = a_neg ^ b_neg;

  ula_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clock  (clock),
    .reset  (reset),
    .load_i (iter_load),
`ifdef ULA_DIV_EN
    .div_i  (controle == OP_DIV),
`endif
    .op_a_i (mag_a),
    .op_b_i (mag_b),
    .last_o (iter_last),
    .hi_o   (iter_hi),
    .lo_o   (iter_lo)
  );

  // Sign correction applied in the FIX state
  always_comb begin
    prod = {iter_hi, iter_lo};
    if (neg_q) prod = -prod;
    {fix_hi, fix_lo} = prod;
`ifdef ULA_DIV_EN
    // Quotient truncates toward zero; remainder follows the dividend sign.
    if (div_op_q) begin
      fix_lo = neg_q ? -iter_lo : iter_lo;
      fix_hi = rem_neg_q ? -iter_hi : iter_hi;
    end
`endif
  end

  // Control FSM: next state and output register updates
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    flag_d    = flag_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    iter_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (controle == OP_MUL) begin
            iter_load = 1'b1;
            state_d   = RUN;
          end
`ifdef ULA_DIV_EN
          else if (controle == OP_DIV && in2 != '0) begin
            iter_load = 1'b1;
            state_d   = RUN;
          end else if (controle == OP_DIV) begin
            res_d  = '0;
            lo_d   = '0;
            hi_d   = in1;
            flag_d = 1'b0;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end
`endif
          else begin
            res_d  = alu_res;
            hi_d   = '0;
            lo_d   = '0;
            flag_d = alu_flag;
            dz_d   = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (iter_last) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        res_d   = fix_lo;
        lo_d    = fix_lo;
        hi_d    = fix_hi;
        flag_d  = 1'b0;
        dz_d    = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flag_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
`ifdef ULA_DIV_EN
      div_op_q  <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flag_q  <= flag_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      if (iter_load) begin
        neg_q <= neg_d;
`ifdef ULA_DIV_EN
        div_op_q  <= (controle == OP_DIV);
        rem_neg_q <= a_neg;
`endif
      end
    end
  end

  assign out_res  = res_q;
  assign out_hi   = hi_q;
  assign out_lo   = lo_q;
  assign out1     = flag_q;
  assign div_zero = dz_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised, multi-cycle successor of the processor's combinational ALU. It keeps the 4-bit `controle` opcode map and generalises the operand width. It adds:
- signed/unsigned mode;
- an iterative multiplier producing a full double-width HI/LO product;
- an iterative divider producing quotient and remainder;
- a start/busy/done handshake, so the control unit can stall the pipeline during long operations.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 8 and even.
- `SHAMT_W`, `$clog2(WIDTH)`: shift-amount width (localparam, not overridable).

Ports:
- `clock`: in, 1, single clock; all state on rising edge.
- `reset`: in, 1, asynchronous, active-high; clears all state and outputs.
- `start`: in, 1, launches the operation in `controle` with `in1`/`in2`/`signed_op`; these are sampled only on the accepting edge.
- `controle`: in, 4, opcode (map below).
- `signed_op`: in, 1, 1 = two's-complement compare/mul/div/right shift.
- `in1`, `in2`: in, WIDTH, operands.
- `out_res`: out, WIDTH, primary result (LO for mul/div).
- `out_hi`: out, WIDTH, product high half / remainder; 0 for other ops.
- `out_lo`: out, WIDTH, product low half / quotient; equals `out_res` for mul/div, 0 otherwise.
- `out1`: out, 1, compare flag.
- `div_zero`: out, 1, last division had `in2 == 0`.
- `busy`: out, 1, operation in flight; `start` is ignored while high.
- `done`: out, 1, one-cycle pulse; result outputs are valid from this cycle.

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR.
  - 0110 LT, 0111 GT, 1000 EQ, 1001 LE, 1010 GE, 1101 NE: `out_res` = 1/0 and `out1` = same bit.
  - 1011 SLL, 1100 SRL/SRA by `in2[SHAMT_W-1:0]`; SRA when `signed_op` = 1.
  - Others: result 0, `out1` = 0.
- FSM states IDLE, RUN, FIX:
  - IDLE + `start` + single-cycle opcode: registers result, pulses `done`, stays in IDLE.
  - IDLE + `start` + MUL/DIV with nonzero divisor: latches operand magnitudes and sign flags, loads counter = WIDTH, goes to RUN.
  - RUN: one shift-add (MUL) or restoring-subtract (DIV) step per cycle. At counter 0, goes to FIX.
  - FIX: applies sign correction, writes `out_hi`/`out_lo`/`out_res`, pulses `done`, returns to IDLE.
- Arithmetic rules:
  - ADD/SUB/SLL wrap modulo 2^WIDTH.
  - MUL result is the exact 2·WIDTH product.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
  - Signed −2^(W−1) / −1 gives quotient 0x80..0, remainder 0 (wrap, no flag).
- Divide by zero is single-cycle: `out_lo` = `out_res` = 0, `out_hi` = `in1`, `div_zero` = 1. Any other operation clears `div_zero`.
- All result outputs hold their value until the next `done`.

## Timing
- Reset value: every output is 0 and FSM is IDLE. Reset asserted mid-RUN aborts the operation; no `done` is produced.
- Single-cycle ops: `start` sampled at edge N → results and `done` = 1 after edge N. `busy` stays 0.
- MUL/DIV latency is WIDTH + 1 edges:
  - `busy` = 1 after edge N.
  - `done` = 1 and `busy` = 0 after edge N + WIDTH + 1 (edge N+33 for WIDTH = 32).
- `start` while `busy` is ignored, with no side effects.
- `start` in the `done` cycle is accepted, giving back-to-back throughput.

## Configuration
- `ULA_DIV_EN` defined: the divider datapath and DIV opcode behave as above.
- `ULA_DIV_EN` undefined: no divider logic is built. 0011 behaves as an unknown opcode: result 0, latency 1, `div_zero` stays 0, `out_hi`/`out_lo` = 0. MUL is unaffected.

## Structure
- Package `ula_pkg` holds:
  - opcode localparams `OP_ADD` … `OP_SNE`;
  - FSM state enum `ula_state_t` (IDLE, RUN, FIX).
- Sub-module `ula_muldiv_iter` contains the shared 2·WIDTH shift register, counter, and add/subtract step. The top level keeps the single-cycle ops, sign handling, FSM, and output registers.

## Test plan
- Unsigned MUL 0xFFFFFFFF × 0xFFFFFFFF → `out_hi` = 0xFFFFFFFE, `out_lo` = 0x00000001; `done` exactly 33 edges after `start`; `busy` high in between.
- Signed DIV −7 / 2 (0xFFFFFFF9, 0x2) → `out_lo` = 0xFFFFFFFD, `out_hi` = 0xFFFFFFFF. Unsigned DIV 100 / 7 → 14 r 2.
- DIV 100 / 0 → `done` after 1 edge, `out_lo` = 0, `out_hi` = 100, `div_zero` = 1. A following ADD clears `div_zero`.
- LT 0xFFFFFFFF vs 1: `signed_op` = 1 → `out1` = 1; `signed_op` = 0 → `out1` = 0. SRA 0x80000000 by 4 → 0xF8000000.
- `start` MUL, then pulse `start` ADD at cycle 5 (ignored), then assert `reset` at cycle 10:
  - all outputs 0 and no `done`;
  - after reset, ADD 3 + 4 → `out_res` = 7 in 1 edge.
- Back-to-back: new MUL `start` in the `done` cycle of the previous MUL is accepted, and `done` follows 33 edges later.
